// File: rtl/ahb_vga_wbuf.sv
// rtl/ahb_vga_wbuf.sv - AHB-Lite VGA write buffer: posted-write FIFO, CTRL/STATUS, layer mux (option: AHB_VGA_WBUF_IRQ_EN)
module ahb_vga_wbuf #(
  parameter int FIFO_DEPTH = 4,
  parameter int PIX_W      = 8,
  parameter int IMG_AW     = 14,
  parameter int X_W        = 10,
  parameter int SPLIT_RST  = 240
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic              HREADY,
  input  logic              HWRITE,
  input  logic [1:0]        HTRANS,
  input  logic [31:0]       HADDR,
  input  logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  input  logic              scroll,
  output logic              console_we,
  output logic [PIX_W-1:0]  console_wdata,
  output logic              image_we,
  output logic [IMG_AW-1:0] image_addr,
  output logic [PIX_W-1:0]  image_wdata,
  input  logic [X_W-1:0]    pixel_x,
  input  logic [PIX_W-1:0]  console_rgb,
  input  logic [PIX_W-1:0]  image_rgb,
  output logic [PIX_W-1:0]  rgb_out
`ifdef AHB_VGA_WBUF_IRQ_EN
  ,
  output logic              IRQ
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = 1 + IMG_AW + PIX_W;

  // Captured address phase
  logic        dph_q, dph_d;
  logic        dwr_q, dwr_d;
  logic [23:0] doff_q, doff_d;

  // FIFO state; entry = {is_image, address, data}
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  // CTRL register
  logic           en_q, en_d;
  logic [X_W-1:0] split_q, split_d;
`ifdef AHB_VGA_WBUF_IRQ_EN
  logic           ien_q, ien_d;
  logic           irq_q, irq_d;
`endif

  // Registered drain strobes and display colour
  logic              cwe_q, cwe_d, iwe_q, iwe_d;
  logic [PIX_W-1:0]  cdata_q, cdata_d, idata_q, idata_d;
  logic [IMG_AW-1:0] iaddr_q, iaddr_d;
  logic [PIX_W-1:0]  rgb_q, rgb_d;

  logic off_console, off_ctrl, off_status, off_image;
  logic posted_wr, ctrl_wr, fifo_full, fifo_empty, push, pop;
  logic [ENT_W-1:0]  head;
  logic              head_kind;
  logic [IMG_AW-1:0] head_addr;
  logic [PIX_W-1:0]  head_data;
  logic [31:0]       ctrl_word, status_word;
  logic              unused_bits;

  assign off_console = (doff_q == 24'h000000);
  assign off_ctrl    = (doff_q == 24'h000004);
  assign off_status  = (doff_q == 24'h000008);
  assign off_image   = (doff_q[23:16] != 8'h00);

  assign posted_wr  = dph_q & dwr_q & (off_console | off_image);
  assign ctrl_wr    = dph_q & dwr_q & off_ctrl;
  assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);

  // A full FIFO stalls the posted write; the push lands on the first non-full cycle
  assign HREADYOUT = ~(posted_wr & fifo_full);
  assign push      = posted_wr & ~fifo_full;

  assign head      = mem_q[rptr_q];
  assign head_kind = head[ENT_W-1];
  assign head_addr = head[PIX_W +: IMG_AW];
  assign head_data = head[PIX_W-1:0];

  // Only a console head is held by scroll, and it blocks everything behind it
  assign pop = ~fifo_empty & (head_kind | ~scroll);

  assign unused_bits = ^{HADDR[31:24], HWDATA, HTRANS[0]};

  // Next-state logic for bus capture, FIFO bookkeeping, CTRL and registered outputs
  always_comb begin
    dph_d  = dph_q;
    dwr_d  = dwr_q;
    doff_d = doff_q;
    if (HREADY) begin
      dph_d  = HSEL & HTRANS[1];
      dwr_d  = HWRITE;
      doff_d = HADDR[23:0];
    end

    wptr_d  = push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PTR_W'(1) : rptr_q;
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LVL_W'(1);
    end

    en_d    = en_q;
    split_d = split_q;
    if (ctrl_wr) begin
      en_d    = HWDATA[0];
      split_d = HWDATA[X_W+15:16];
    end
`ifdef AHB_VGA_WBUF_IRQ_EN
    ien_d = ien_q;
    if (ctrl_wr) begin
      ien_d = HWDATA[1];
    end
    irq_d = ien_q & fifo_empty;
`endif

    cwe_d   = pop & ~head_kind;
    iwe_d   = pop & head_kind;
    cdata_d = (pop & ~head_kind) ? head_data : '0;
    idata_d = (pop & head_kind) ? head_data : '0;
    iaddr_d = (pop & head_kind) ? head_addr : '0;

    rgb_d = '0;
    if (en_q) begin
      rgb_d = (pixel_x < split_q) ? console_rgb : image_rgb;
    end
  end

  // State registers with synchronous reset; reset drops queued and in-flight writes
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dph_q   <= 1'b0;
      dwr_q   <= 1'b0;
      doff_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      en_q    <= 1'b1;
      split_q <= X_W'(SPLIT_RST);
      cwe_q   <= 1'b0;
      iwe_q   <= 1'b0;
      cdata_q <= '0;
      idata_q <= '0;
      iaddr_q <= '0;
      rgb_q   <= '0;
    end else begin
      dph_q   <= dph_d;
      dwr_q   <= dwr_d;
      doff_q  <= doff_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      en_q    <= en_d;
      split_q <= split_d;
      cwe_q   <= cwe_d;
      iwe_q   <= iwe_d;
      cdata_q <= cdata_d;
      idata_q <= idata_d;
      iaddr_q <= iaddr_d;
      rgb_q   <= rgb_d;
    end
  end

`ifdef AHB_VGA_WBUF_IRQ_EN
  // Interrupt enable and registered FIFO-empty interrupt level
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ien_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ien_q <= ien_d;
      irq_q <= irq_d;
    end
  end

  assign IRQ = irq_q;
`endif

  // FIFO storage; contents are don't-care while the level says empty
  always_ff @(posedge HCLK) begin
    if (push) begin
      mem_q[wptr_q] <= {off_image, doff_q[IMG_AW+1:2], HWDATA[PIX_W-1:0]};
    end
  end

  // Read mux: CTRL and STATUS are visible combinationally in a read data phase
  always_comb begin
    ctrl_word              = '0;
    ctrl_word[0]           = en_q;
    ctrl_word[X_W+15:16]   = split_q;
`ifdef AHB_VGA_WBUF_IRQ_EN
    ctrl_word[1]           = ien_q;
`endif
    status_word            = '0;
    status_word[4:0]       = 5'(level_q);
    status_word[8]         = fifo_empty;
    status_word[9]         = fifo_full;
    status_word[10]        = scroll;
    HRDATA = '0;
    if (dph_q && !dwr_q) begin
      if (off_ctrl) begin
        HRDATA = ctrl_word;
      end else if (off_status) begin
        HRDATA = status_word;
      end
    end
  end

  assign console_we    = cwe_q;
  assign console_wdata = cdata_q;
  assign image_we      = iwe_q;
  assign image_addr    = iaddr_q;
  assign image_wdata   = idata_q;
  assign rgb_out       = rgb_q;

endmodule

// File: tb/tb_ahb_vga_wbuf.sv
// tb/tb_ahb_vga_wbuf.sv - self-checking bench for ahb_vga_wbuf with a queue-based reference model
module tb_ahb_vga_wbuf;
  localparam int DEPTH = 4;
  localparam int SPLIT_RST = 240;

  logic        HCLK = 1'b0;
  logic        HRESET, HSEL, HREADY, HWRITE;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic        HREADYOUT, scroll;
  logic        console_we, image_we;
  logic [7:0]  console_wdata, image_wdata;
  logic [13:0] image_addr;
  logic [9:0]  pixel_x;
  logic [7:0]  console_rgb, image_rgb, rgb_out;
`ifdef AHB_VGA_WBUF_IRQ_EN
  logic        IRQ;
`endif

  int vectors = 0;
  int errors  = 0;
  bit rand_pix = 1'b1;
  bit rand_scroll = 1'b0;

  typedef struct packed {
    logic       kind;
    logic [13:0] addr;
    logic [7:0] data;
  } ent_t;

  ent_t seen_q[$];

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  ahb_vga_wbuf dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
    .scroll(scroll), .console_we(console_we), .console_wdata(console_wdata),
    .image_we(image_we), .image_addr(image_addr), .image_wdata(image_wdata),
    .pixel_x(pixel_x), .console_rgb(console_rgb), .image_rgb(image_rgb), .rgb_out(rgb_out)
`ifdef AHB_VGA_WBUF_IRQ_EN
    , .IRQ(IRQ)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of posted writes plus the programmer-visible registers
  ent_t        mq[$];
  bit          m_dph, m_dwr;
  logic [23:0] m_off;
  bit          m_en, m_ien;
  logic [9:0]  m_split;
  bit          m_cwe, m_iwe, m_irq;
  logic [7:0]  m_cdata, m_idata, m_rgb;
  logic [13:0] m_iaddr;

  function automatic bit is_posted(input logic [23:0] off);
    return (off == 24'h0) || (off[23:16] != 8'h0);
  endfunction

  function automatic logic m_hready();
    return !(m_dph && m_dwr && is_posted(m_off) && mq.size() == DEPTH);
  endfunction

  function automatic logic [31:0] m_rdata();
    logic [31:0] r;
    r = '0;
    if (m_dph && !m_dwr) begin
      if (m_off == 24'h4) begin
        r[0] = m_en;
        r[25:16] = m_split;
`ifdef AHB_VGA_WBUF_IRQ_EN
        r[1] = m_ien;
`endif
      end else if (m_off == 24'h8) begin
        r[4:0] = 5'(mq.size());
        r[8]   = (mq.size() == 0);
        r[9]   = (mq.size() == DEPTH);
        r[10]  = scroll;
      end
    end
    return r;
  endfunction

  always @(posedge HCLK) begin
    ent_t e;
    int   n;
    bit   posted_now, hr;
    if (HRESET) begin
      mq.delete();
      m_dph = 0; m_dwr = 0; m_off = '0;
      m_en = 1; m_split = 10'(SPLIT_RST); m_ien = 0;
      m_cwe = 0; m_iwe = 0; m_cdata = '0; m_idata = '0; m_iaddr = '0;
      m_rgb = '0; m_irq = 0;
    end else begin
      n = mq.size();
      posted_now = m_dph && m_dwr && is_posted(m_off);
      hr = !(posted_now && n == DEPTH);
      m_rgb = !m_en ? 8'h0 : ((pixel_x < m_split) ? console_rgb : image_rgb);
      m_irq = m_ien && (n == 0);
      m_cwe = 0; m_iwe = 0; m_cdata = '0; m_idata = '0; m_iaddr = '0;
      if (n > 0 && (mq[0].kind || !scroll)) begin
        e = mq.pop_front();
        if (e.kind) begin
          m_iwe = 1; m_idata = e.data; m_iaddr = e.addr;
        end else begin
          m_cwe = 1; m_cdata = e.data;
        end
      end
      if (posted_now && n < DEPTH) begin
        e.kind = (m_off[23:16] != 8'h0);
        e.addr = m_off[15:2];
        e.data = HWDATA[7:0];
        mq.push_back(e);
      end
      if (m_dph && m_dwr && m_off == 24'h4) begin
        m_en = HWDATA[0];
        m_split = HWDATA[25:16];
`ifdef AHB_VGA_WBUF_IRQ_EN
        m_ien = HWDATA[1];
`endif
      end
      if (hr) begin
        m_dph = HSEL && HTRANS[1];
        m_dwr = HWRITE;
        m_off = HADDR[23:0];
      end
    end
  end

  // Compare process: every cycle, just after the active edge
  always @(posedge HCLK) begin
    ent_t s;
    #1;
    check("hreadyout", HREADYOUT, m_hready());
    check("hrdata", HRDATA, m_rdata());
    check("console_we", console_we, m_cwe);
    check("console_wdata", console_wdata, m_cdata);
    check("image_we", image_we, m_iwe);
    check("image_addr", image_addr, m_iaddr);
    check("image_wdata", image_wdata, m_idata);
    check("rgb_out", rgb_out, m_rgb);
`ifdef AHB_VGA_WBUF_IRQ_EN
    check("irq", IRQ, m_irq);
`endif
    if (console_we === 1'b1) begin
      s.kind = 0; s.addr = '0; s.data = console_wdata; seen_q.push_back(s);
    end
    if (image_we === 1'b1) begin
      s.kind = 1; s.addr = image_addr; s.data = image_wdata; seen_q.push_back(s);
    end
  end

  // Background pixel and scroll stimulus
  always @(negedge HCLK) begin
    if (rand_pix) begin
      pixel_x = 10'($urandom);
      console_rgb = 8'($urandom);
      image_rgb = 8'($urandom);
    end
    if (rand_scroll && $urandom_range(0, 7) == 0) scroll = ~scroll;
  end

  task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d, output logic [31:0] rd);
    int n;
    @(negedge HCLK);
    HSEL = 1; HTRANS = 2'b10; HWRITE = w; HADDR = a;
    @(negedge HCLK);
    HSEL = 0; HTRANS = 2'b00; HWDATA = d;
    n = 0;
    while (HREADYOUT !== 1'b1 && n < 200) begin
      @(negedge HCLK);
      n++;
    end
    if (n >= 200) begin
      vectors++; errors++;
      $display("FAIL bus_timeout: got HREADYOUT=%b after %0d cycles, expected 1", HREADYOUT, n);
    end
    rd = HRDATA;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] t;
    xfer(1'b1, a, d, t);
  endtask

  task automatic rdr(input logic [31:0] a, output logic [31:0] rd);
    xfer(1'b0, a, 32'h0, rd);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish, expected completion");
    errors++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd, r, a, d;
    int op;
    HRESET = 1; HSEL = 0; HTRANS = 0; HWRITE = 0; HADDR = 0; HWDATA = 0;
    scroll = 0; pixel_x = 0; console_rgb = 0; image_rgb = 0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 0;

    // Reset state
    check("rst_hreadyout", HREADYOUT, 1);
    check("rst_strobes", {console_we, image_we}, 0);
    check("rst_rgb", rgb_out, 0);
    rdr(32'h8, rd); check("rst_status", rd, 32'h100);
    rdr(32'h4, rd); check("rst_ctrl", rd, 32'h00F00001);

    // Console write latency: strobe two cycles after the data phase, one cycle wide
    wr(32'h0, 32'h41);
    @(posedge HCLK); #1 check("lat_c1_we", console_we, 0);
    @(posedge HCLK); #1 check("lat_c2_we", console_we, 1);
    check("lat_c2_data", console_wdata, 8'h41);
    @(posedge HCLK); #1 check("lat_c3_we", console_we, 0);

    // Full FIFO back-pressure while scrolling
    @(negedge HCLK); scroll = 1;
    seen_q.delete();
    for (int i = 0; i < 4; i++) wr(32'h0, 32'h30 + i);
    rdr(32'h8, rd); check("full_status", rd, 32'h604);
    fork
      wr(32'h0, 32'h34);
      begin
        repeat (3) @(negedge HCLK);
        check("full_stall", HREADYOUT, 0);
        scroll = 0;
      end
    join
    repeat (10) @(negedge HCLK);
    check("full_count", seen_q.size(), 5);
    for (int i = 0; i < 5 && i < seen_q.size(); i++) begin
      check("full_order", {seen_q[i].kind, seen_q[i].data}, {1'b0, 8'(8'h30 + i)});
    end
    check("full_ready", HREADYOUT, 1);

    // Console head blocks a later image write
    @(negedge HCLK); scroll = 1;
    seen_q.delete();
    wr(32'h0, 32'h55);
    wr(32'h00010008, 32'hA7);
    repeat (6) @(negedge HCLK);
    check("block_none", seen_q.size(), 0);
    scroll = 0;
    repeat (6) @(negedge HCLK);
    check("block_count", seen_q.size(), 2);
    if (seen_q.size() == 2) begin
      check("block_first", seen_q[0], {1'b0, 14'h0, 8'h55});
      check("block_second", seen_q[1], {1'b1, 14'h2, 8'hA7});
    end

    // Layer mux around the split column
    rand_pix = 0;
    wr(32'h4, 32'h00640001);
    @(negedge HCLK); pixel_x = 99; console_rgb = 8'h11; image_rgb = 8'h22;
    @(posedge HCLK); #1 check("mux_99", rgb_out, 8'h11);
    @(negedge HCLK); pixel_x = 100;
    @(posedge HCLK); #1 check("mux_100", rgb_out, 8'h22);
    rdr(32'h4, rd); check("mux_ctrl", rd, 32'h00640001);
    wr(32'h4, 32'h00000001);
    @(negedge HCLK); pixel_x = 0;
    @(posedge HCLK); #1 check("split0", rgb_out, 8'h22);
    wr(32'h4, 32'h0);
    @(posedge HCLK); @(posedge HCLK); #1 check("disabled", rgb_out, 8'h00);
    rand_pix = 1;

    // Reset with writes queued
    @(negedge HCLK); scroll = 1;
    seen_q.delete();
    for (int i = 0; i < 3; i++) wr(32'h0, 32'h60 + i);
    @(negedge HCLK); HRESET = 1;
    @(negedge HCLK); HRESET = 0; scroll = 0;
    repeat (8) @(negedge HCLK);
    check("rst2_none", seen_q.size(), 0);
    rdr(32'h8, rd); check("rst2_status", rd, 32'h100);
    rdr(32'h4, rd); check("rst2_ctrl", rd, 32'h00F00001);

`ifdef AHB_VGA_WBUF_IRQ_EN
    wr(32'h4, 32'h00F00003);
    repeat (2) @(negedge HCLK);
    check("irq_idle", IRQ, 1);
    scroll = 1;
    wr(32'h0, 32'h7E);
    repeat (2) @(negedge HCLK);
    check("irq_queued", IRQ, 0);
    scroll = 0;
    repeat (4) @(negedge HCLK);
    check("irq_drained", IRQ, 1);
`endif

    // Randomised traffic against the model
    rand_scroll = 1;
    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 9);
      r = $urandom();
      d = $urandom();
      case (op)
        0, 1, 2, 3: wr({r[31:24], 24'h0}, d);
        4, 5: begin
          a = {r[31:24], 8'($urandom_range(1, 255)), r[15:2], 2'b00};
          wr(a, d);
        end
        6: begin
          d[0] = ($urandom_range(0, 3) != 0);
          wr(32'h4, d);
        end
        7: rdr(32'h4, rd);
        8: rdr(32'h8, rd);
        default: begin
          a = {r[31:24], 8'h00, 4'h0, r[11:2], 2'b00};
          if (a[15:0] <= 16'h8) a[15:0] = 16'h000C;
          if (r[0]) wr(a, d); else rdr(a, rd);
          if (!r[0]) check("unmapped_rd", rd, 0);
        end
      endcase
      repeat ($urandom_range(0, 2)) @(negedge HCLK);
    end
    rand_scroll = 0;
    @(negedge HCLK); scroll = 0;
    repeat (12) @(negedge HCLK);
    rdr(32'h8, rd); check("final_status", rd, 32'h100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
